// File: rtl/fb_pkg.sv
// Shared framebuffer constants, pixel layout and write-engine state encoding;
// the scanout side imports the same package.
package fb_pkg;

    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int ADDR_W    = 17;

    localparam int PIX_R_MSB = 15;
    localparam int PIX_R_LSB = 11;
    localparam int PIX_G_MSB = 10;
    localparam int PIX_G_LSB = 6;
    localparam int PIX_B_MSB = 5;
    localparam int PIX_B_LSB = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2
    } fb_state_e;

    // Keep the top five bits of each channel; bit 0 stays zero.
    function automatic logic [15:0] pack_rgb888(input logic [7:0] r,
                                                 input logic [7:0] g,
                                                 input logic [7:0] b);
        logic [15:0] pix;
        pix = 16'd0;
        pix[PIX_R_MSB:PIX_R_LSB] = r[7:3];
        pix[PIX_G_MSB:PIX_G_LSB] = g[7:3];
        pix[PIX_B_MSB:PIX_B_LSB] = b[7:3];
        return pix;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Start address, row skip and row-major address stepper for one rectangle.
// The row base y*FB_WIDTH is built from shifted copies of y, no multiplier.
module fb_addr_gen #(
    parameter int FB_WIDTH = 400,
    parameter int ADDR_W   = 17
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [8:0]        x_i,
    input  logic [7:0]        y_i,
    input  logic [8:0]        w_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              row_last_o
);

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] row_skip;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        col_q;

    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
        logic [ADDR_W-1:0] acc;
        acc = {ADDR_W{1'b0}};
        for (int i = 0; i < ADDR_W; i++) begin
            acc = acc + ((((FB_WIDTH >> i) & 1) != 0) ? (ADDR_W'(y) << i)
                                                      : {ADDR_W{1'b0}});
        end
        return acc;
    endfunction

    assign start_addr = row_base(y_i) + ADDR_W'(x_i);
    assign row_skip   = ADDR_W'(FB_WIDTH) - ADDR_W'(w_i);
    assign row_last_o = (col_q == (w_i - 9'd1));
    assign addr_o     = addr_q;

    // Address/column stepper: load at setup, step on each retired write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= {ADDR_W{1'b0}};
            col_q  <= 9'd0;
        end else if (load_i) begin
            addr_q <= start_addr;
            col_q  <= 9'd0;
        end else if (advance_i) begin
            if (row_last_o) begin
                addr_q <= addr_q + row_skip + ADDR_W'(1'b1);
                col_q  <= 9'd0;
            end else begin
                addr_q <= addr_q + ADDR_W'(1'b1);
                col_q  <= col_q + 9'd1;
            end
        end else begin
            addr_q <= addr_q;
            col_q  <= col_q;
        end
    end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: accepts a command, then writes one packed pixel per cycle.
// Define FB_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module fb_rect_writer #(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int ADDR_W    = fb_pkg::ADDR_W
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);
    import fb_pkg::*;

    fb_state_e   state_q;
    logic [8:0]  x_q, w_q, ew_q;
    logic [7:0]  y_q, h_q, eh_q, row_q;
    logic [15:0] fb_data_q;
    logic        cmd_ready_q, busy_q, done_q, cmd_err_q, fb_we_q;

    logic [9:0]  sum_x, sum_y;
    logic [8:0]  ew_d;
    logic [7:0]  eh_d;
    logic        reject_d, empty_d;
    logic        retire, row_last, last_pix, load_addr;

    // Effective rectangle size, evaluated while in SETUP.
    always_comb begin
        sum_x    = {1'b0, x_q} + {1'b0, w_q};
        sum_y    = {2'b00, y_q} + {2'b00, h_q};
        ew_d     = w_q;
        eh_d     = h_q;
        reject_d = 1'b0;
`ifdef FB_CLIP_EN
        if (({1'b0, x_q} >= 10'(FB_WIDTH)) || ({2'b00, y_q} >= 10'(FB_HEIGHT))) begin
            ew_d = 9'd0;
            eh_d = 8'd0;
        end else begin
            ew_d = (sum_x > 10'(FB_WIDTH))  ? 9'(10'(FB_WIDTH) - {1'b0, x_q})   : w_q;
            eh_d = (sum_y > 10'(FB_HEIGHT)) ? 8'(10'(FB_HEIGHT) - {2'b00, y_q}) : h_q;
        end
`else
        if ((sum_x > 10'(FB_WIDTH)) || (sum_y > 10'(FB_HEIGHT))) begin
            reject_d = 1'b1;
            ew_d     = 9'd0;
            eh_d     = 8'd0;
        end else begin
            reject_d = 1'b0;
        end
`endif
        empty_d = (ew_d == 9'd0) || (eh_d == 8'd0);
    end

    assign retire    = fb_we_q && fb_ready;
    assign last_pix  = row_last && (row_q == (eh_q - 8'd1));
    assign load_addr = (state_q == ST_SETUP) && !empty_d;

    fb_addr_gen #(
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk_25mhz),
        .reset_i    (reset),
        .load_i     (load_addr),
        .advance_i  (retire),
        .x_i        (x_q),
        .y_i        (y_q),
        .w_i        (ew_q),
        .addr_o     (fb_addr),
        .row_last_o (row_last)
    );

    // Command FSM with registered handshake and status outputs.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= 9'd0;
            y_q         <= 8'd0;
            w_q         <= 9'd0;
            h_q         <= 8'd0;
            ew_q        <= 9'd0;
            eh_q        <= 8'd0;
            row_q       <= 8'd0;
            fb_data_q   <= 16'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            fb_we_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        x_q         <= cmd_x;
                        y_q         <= cmd_y;
                        w_q         <= cmd_w;
                        h_q         <= cmd_h;
                        fb_data_q   <= pack_rgb888(red, green, blue);
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    ew_q  <= ew_d;
                    eh_q  <= eh_d;
                    row_q <= 8'd0;
                    if (empty_d) begin
                        done_q      <= 1'b1;
                        cmd_err_q   <= reject_d;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        fb_we_q <= 1'b1;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (retire && last_pix) begin
                        fb_we_q     <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (retire && row_last) begin
                        row_q <= row_q + 8'd1;
                    end else begin
                        row_q <= row_q;
                    end
                end
                default: begin
                    fb_we_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign fb_data   = fb_data_q;
    assign fb_we     = fb_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed cases plus random rectangles
// checked against an arithmetic model of the expected write list.
module tb_fb_rect_writer;

    logic        clk_25mhz = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x = 9'd0;
    logic [7:0]  cmd_y = 8'd0;
    logic [8:0]  cmd_w = 9'd0;
    logic [7:0]  cmd_h = 8'd0;
    logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    logic        busy, done, cmd_err;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_done = -10;
    int exp_q[$];
    int exp_data;
    int exp_err;
    bit pend_arm = 1'b0;
    int pend_x, pend_y, pend_w, pend_h, pend_r, pend_g, pend_b;

    fb_rect_writer dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected write list for one command, straight from the screen geometry.
    task automatic build_model(input int x, input int y, input int w, input int h,
                               input int r, input int g, input int b);
        int ew, eh;
        exp_q.delete();
        exp_data = ((r >> 3) << 11) | ((g >> 3) << 6) | ((b >> 3) << 1);
`ifdef FB_CLIP_EN
        exp_err = 0;
        if (x >= 400 || y >= 240) begin
            ew = 0;
            eh = 0;
        end else begin
            ew = (w < 400 - x) ? w : 400 - x;
            eh = (h < 240 - y) ? h : 240 - y;
        end
`else
        if (x + w > 400 || y + h > 240) begin
            exp_err = 1;
            ew = 0;
            eh = 0;
        end else begin
            exp_err = 0;
            ew = w;
            eh = h;
        end
`endif
        for (int rr = 0; rr < eh; rr++)
            for (int cc = 0; cc < ew; cc++)
                exp_q.push_back((y + rr) * 400 + x + cc);
    endtask

    // Issue one command (called at a falling edge) and follow it to completion.
    // mode: 0 ready always high, 1 random stalls, 2 three-cycle stall on 2nd write.
    // rst_at: write index at which reset is pulsed (-1 for none).
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input int r, input int g, input int b,
                           input int mode, input int rst_at, input bit b2b);
        int acc, t, ret_cyc, popped, stall, first_we;
        bit fin;
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
        red = 8'(r); green = 8'(g); blue = 8'(b);
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk_25mhz);
            t++;
        end
        if (t >= 100) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (b2b) check_eq("b2b_accept_cyc", acc, last_done + 1);
        build_model(x, y, w, h, r, g, b);
        popped = 0; stall = 0; first_we = -1; ret_cyc = acc; fin = 1'b0;
        fb_ready = 1'b1;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk_25mhz);
            if (cyc == acc) begin
                check_eq("setup_busy", busy, 1);
                check_eq("setup_ready", cmd_ready, 0);
                if (pend_arm) begin
                    cmd_x = 9'(pend_x); cmd_y = 8'(pend_y); cmd_w = 9'(pend_w); cmd_h = 8'(pend_h);
                    red = 8'(pend_r); green = 8'(pend_g); blue = 8'(pend_b);
                    pend_arm = 1'b0;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (cmd_err && !done) check_eq("stray_err", cmd_err, 0);
            if (fb_we) begin
                if (first_we < 0) begin
                    first_we = cyc;
                    check_eq("first_we_cyc", cyc, acc + 1);
                end
                if (exp_q.size() == 0) begin
                    check_eq("extra_write", fb_we, 0);
                end else begin
                    check_eq("wr_addr", fb_addr, exp_q[0]);
                    check_eq("wr_data", fb_data, exp_data);
                end
            end
            if (rst_at >= 0 && fb_we && popped == rst_at) begin
                reset = 1'b1;
                @(negedge clk_25mhz);
                check_eq("rst_we", fb_we, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_ready", cmd_ready, 0);
                reset = 1'b0;
                @(negedge clk_25mhz);
                check_eq("post_rst_ready", cmd_ready, 1);
                check_eq("post_rst_we", fb_we, 0);
                check_eq("post_rst_done", done, 0);
                exp_q.delete();
                fin = 1'b1;
            end else if (done) begin
                check_eq("done_cyc", cyc, ret_cyc + 1);
                check_eq("done_err", cmd_err, exp_err);
                check_eq("done_we", fb_we, 0);
                check_eq("done_ready", cmd_ready, 1);
                check_eq("done_busy", busy, 0);
                check_eq("writes_left", exp_q.size(), 0);
                last_done = cyc;
                fin = 1'b1;
            end else begin
                case (mode)
                    1: fb_ready = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (fb_we && popped == 1 && stall < 3) begin
                            fb_ready = 1'b0;
                            stall++;
                        end else begin
                            fb_ready = 1'b1;
                        end
                    end
                    default: fb_ready = 1'b1;
                endcase
                if (fb_we && fb_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    popped++;
                    ret_cyc = cyc;
                end
            end
        end
        if (!fin) check_eq("done_timeout", 32'd0, 32'd1);
        fb_ready = 1'b1;
    endtask

    initial begin
        int x, y, w, h;
        reset = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_fb_we", fb_we, 0);
        check_eq("rst_fb_addr", fb_addr, 0);
        check_eq("rst_fb_data", fb_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cmd_err", cmd_err, 0);
        reset = 1'b0;
        @(negedge clk_25mhz);
        check_eq("idle_ready", cmd_ready, 1);
        check_eq("idle_busy", busy, 0);

        run_cmd(0, 0, 1, 1, 8'hFF, 8'h00, 8'hFF, 0, -1, 1'b0);
        run_cmd(398, 239, 3, 2, 8'h12, 8'h34, 8'h56, 0, -1, 1'b0);
        run_cmd(10, 1, 2, 2, 8'hA5, 8'h5A, 8'hC3, 0, -1, 1'b0);
        run_cmd(10, 1, 2, 2, 8'hA5, 8'h5A, 8'hC3, 2, -1, 1'b0);
        run_cmd(0, 5, 4, 1, 8'h80, 8'h40, 8'h20, 0, 1, 1'b0);
        run_cmd(399, 239, 1, 1, 8'h08, 8'h10, 8'hF8, 1, -1, 1'b0);

        pend_arm = 1'b1;
        pend_x = 5; pend_y = 7; pend_w = 1; pend_h = 1;
        pend_r = 8'h3C; pend_g = 8'hC3; pend_b = 8'h77;
        run_cmd(20, 20, 0, 3, 8'h11, 8'h22, 8'h33, 0, -1, 1'b0);
        run_cmd(pend_x, pend_y, pend_w, pend_h, pend_r, pend_g, pend_b, 0, -1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            x = ($urandom_range(0, 1) != 0) ? $urandom_range(370, 420) : $urandom_range(0, 399);
            y = ($urandom_range(0, 1) != 0) ? $urandom_range(225, 255) : $urandom_range(0, 239);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) begin
                w = $urandom_range(13, 511);
                h = 1;
            end
            run_cmd(x, y, w, h, $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 1), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
